// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with a multi-cycle shift-add multiplier, a
// restoring divider and a WIDTH-bit accumulator.
//
// A request is accepted only in IDLE when start is high.  op, A and B are
// latched on that edge, so later changes on the inputs cannot disturb the
// operation in flight.  Single-cycle ops complete on the next edge.  MUL and
// DIV/MOD need WIDTH iteration edges.  All outputs are registered.  done
// pulses for one cycle, and the result/flags are held until the next
// completion.
//
// Ports
//   clock      sole clock, rising-edge active
//   rst        asynchronous active-low reset
//   start      request pulse, sampled only in IDLE
//   op[3:0]    operation code, latched with start
//   A, B       unsigned operands, latched with start
//   result     primary result (modulo 2^WIDTH)
//   result_hi  MUL upper half, DIV/MOD remainder, A on divide-by-zero, else 0
//   busy       high while an operation is in flight
//   done       one-cycle completion pulse
//   overflow   carry / borrow / shifted-out MSB / non-zero MUL upper half
//   zero       result == 0
//   divz       divide-by-zero completion
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic             zero,
   output logic             divz
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   ALL_ONES = {WIDTH{1'b1}};
   localparam logic [2*WIDTH-1:0] ZERO2W   = {(2*WIDTH){1'b0}};

   localparam logic [3:0] OP_INC_A = 4'd0;
   localparam logic [3:0] OP_INC_B = 4'd1;
   localparam logic [3:0] OP_SUB   = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_MUL   = 4'd4;
   localparam logic [3:0] OP_SHR_A = 4'd5;
   localparam logic [3:0] OP_SHL_A = 4'd6;
   localparam logic [3:0] OP_SHR_B = 4'd7;
   localparam logic [3:0] OP_SHL_B = 4'd8;
   localparam logic [3:0] OP_MOD   = 4'd9;
   localparam logic [3:0] OP_AND   = 4'd10;
   localparam logic [3:0] OP_OR    = 4'd11;
   localparam logic [3:0] OP_XOR   = 4'd12;
   localparam logic [3:0] OP_DIV   = 4'd13;
   localparam logic [3:0] OP_ACC   = 4'd14;
   localparam logic [3:0] OP_CLR   = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EXEC = 3'd1,
      S_MUL  = 3'd2,
      S_DIV  = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;       // operand A; quotient shift register in DIV
   logic [WIDTH-1:0]   b_q, b_d;       // operand B; multiplier shift register in MUL
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   result_hi_q, result_hi_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               overflow_q, overflow_d;
   logic               zero_q, zero_d;
   logic               divz_q, divz_d;

   // Single-cycle datapath
   logic [WIDTH:0]     sum_ab_s;
   logic [WIDTH:0]     diff_ab_s;
   logic [WIDTH:0]     acc_sum_s;
   logic [WIDTH-1:0]   exec_res_s;
   logic [WIDTH-1:0]   exec_hi_s;
   logic               exec_ovf_s;
   logic               exec_divz_s;
   logic [WIDTH-1:0]   exec_acc_s;

   // Iterative datapath
   logic [2*WIDTH-1:0] prod_step_s;
   logic [WIDTH:0]     rem_shift_s;
   logic [WIDTH-1:0]   rem_sub_s;
   logic               qbit_s;
   logic [WIDTH-1:0]   rem_next_s;
   logic [WIDTH-1:0]   quot_next_s;

   // Single-cycle ALU evaluated from the latched op/operands and the accumulator
   always_comb begin
      sum_ab_s    = {1'b0, a_q} + {1'b0, b_q};
      diff_ab_s   = {1'b0, a_q} - {1'b0, b_q};
      acc_sum_s   = {1'b0, acc_q} + {1'b0, a_q};
      exec_res_s  = ZERO;
      exec_hi_s   = ZERO;
      exec_ovf_s  = 1'b0;
      exec_divz_s = 1'b0;
      exec_acc_s  = acc_q;
      case (op_q)
         OP_INC_A: begin
            exec_res_s = a_q + ONE;
            exec_ovf_s = (a_q == ALL_ONES);
         end
         OP_INC_B: begin
            exec_res_s = b_q + ONE;
            exec_ovf_s = (b_q == ALL_ONES);
         end
         OP_SUB: begin
            exec_res_s = diff_ab_s[WIDTH-1:0];
            exec_ovf_s = diff_ab_s[WIDTH];   // borrow: A < B
         end
         OP_ADD: begin
            exec_res_s = sum_ab_s[WIDTH-1:0];
            exec_ovf_s = sum_ab_s[WIDTH];
         end
         OP_SHR_A: exec_res_s = {1'b0, a_q[WIDTH-1:1]};
         OP_SHL_A: begin
            exec_res_s = {a_q[WIDTH-2:0], 1'b0};
            exec_ovf_s = a_q[WIDTH-1];
         end
         OP_SHR_B: exec_res_s = {1'b0, b_q[WIDTH-1:1]};
         OP_SHL_B: begin
            exec_res_s = {b_q[WIDTH-2:0], 1'b0};
            exec_ovf_s = b_q[WIDTH-1];
         end
         // DIV/MOD reach the single-cycle path only when B == 0
         OP_MOD, OP_DIV: begin
            exec_res_s  = ALL_ONES;
            exec_hi_s   = a_q;
            exec_divz_s = 1'b1;
         end
         OP_AND: exec_res_s = a_q & b_q;
         OP_OR:  exec_res_s = a_q | b_q;
         OP_XOR: exec_res_s = a_q ^ b_q;
         OP_ACC: begin
            exec_res_s = acc_sum_s[WIDTH-1:0];
            exec_ovf_s = acc_sum_s[WIDTH];
            exec_acc_s = acc_sum_s[WIDTH-1:0];
         end
         OP_CLR: begin
            exec_res_s = ZERO;
            exec_acc_s = ZERO;
         end
         default: begin
            exec_res_s = ZERO;
         end
      endcase
   end

   // One shift-add partial product and one restoring-division quotient bit
   always_comb begin
      if (b_q[0]) begin
         prod_step_s = prod_q + mcand_q;
      end else begin
         prod_step_s = prod_q;
      end
      rem_shift_s = {rem_q, a_q[WIDTH-1]};
      qbit_s      = (rem_shift_s >= {1'b0, b_q});
      // When qbit_s is set the difference is below B, so WIDTH bits suffice
      rem_sub_s   = rem_shift_s[WIDTH-1:0] - b_q;
      if (qbit_s) begin
         rem_next_s = rem_sub_s;
      end else begin
         rem_next_s = rem_shift_s[WIDTH-1:0];
      end
      quot_next_s = {a_q[WIDTH-2:0], qbit_s};
   end

   // Next-state and next-output logic of the control FSM
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      prod_d      = prod_q;
      mcand_d     = mcand_q;
      rem_d       = rem_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      overflow_d  = overflow_q;
      zero_d      = zero_q;
      divz_d      = divz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = A;
               b_d     = B;
               cnt_d   = CNT_ZERO;
               prod_d  = ZERO2W;
               mcand_d = {ZERO, A};
               rem_d   = ZERO;
               busy_d  = 1'b1;
               if (op == OP_MUL) begin
                  state_d = S_MUL;
               end else if (((op == OP_MOD) || (op == OP_DIV)) && (B != ZERO)) begin
                  state_d = S_DIV;
               end else begin
                  state_d = S_EXEC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            result_d    = exec_res_s;
            result_hi_d = exec_hi_s;
            overflow_d  = exec_ovf_s;
            zero_d      = (exec_res_s == ZERO);
            divz_d      = exec_divz_s;
            acc_d       = exec_acc_s;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_FIN;
         end
         S_MUL: begin
            prod_d  = prod_step_s;
            mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            if (cnt_q == CNT_LAST) begin
               cnt_d       = CNT_ZERO;
               result_d    = prod_step_s[WIDTH-1:0];
               result_hi_d = prod_step_s[2*WIDTH-1:WIDTH];
               overflow_d  = (prod_step_s[2*WIDTH-1:WIDTH] != ZERO);
               zero_d      = (prod_step_s[WIDTH-1:0] == ZERO);
               divz_d      = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               state_d     = S_FIN;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = S_MUL;
            end
         end
         S_DIV: begin
            rem_d = rem_next_s;
            a_d   = quot_next_s;
            if (cnt_q == CNT_LAST) begin
               cnt_d = CNT_ZERO;
               if (op_q == OP_DIV) begin
                  result_d = quot_next_s;
                  zero_d   = (quot_next_s == ZERO);
               end else begin
                  result_d = rem_next_s;
                  zero_d   = (rem_next_s == ZERO);
               end
               result_hi_d = rem_next_s;
               overflow_d  = 1'b0;
               divz_d      = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               state_d     = S_FIN;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = S_DIV;
            end
         end
         // A start seen here is dropped; the requester must retry in IDLE
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous reset
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         op_q        <= 4'd0;
         a_q         <= ZERO;
         b_q         <= ZERO;
         acc_q       <= ZERO;
         cnt_q       <= CNT_ZERO;
         prod_q      <= ZERO2W;
         mcand_q     <= ZERO2W;
         rem_q       <= ZERO;
         result_q    <= ZERO;
         result_hi_q <= ZERO;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
         divz_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         prod_q      <= prod_d;
         mcand_q     <= mcand_d;
         rem_q       <= rem_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
         divz_q      <= divz_d;
      end
   end

   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
   assign divz      = divz_q;

endmodule
